// File: rtl/nap_pkg.sv
// Shared nap-timer definitions: state encoding, BCD digit limits and the mm:ss triple.
// The keypad selector and the display decoder use the same definitions.
package nap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } nap_state_t;

    localparam logic [3:0] SEC_UNIT_MAX = 4'd9;
    localparam logic [3:0] SEC_TEN_MAX  = 4'd5;
    localparam logic [3:0] MIN_MAX      = 4'd9;

    typedef struct packed {
        logic [3:0] one_min;
        logic [3:0] ten_sec;
        logic [3:0] one_sec;
    } mmss_t;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second BCD decrement of an m:ss value.
// is_zero_next flags that the decremented value is 0:00.
module bcd_mmss_dec
    import nap_pkg::*;
(
    input  mmss_t cur,
    output mmss_t nxt,
    output logic  is_zero_next
);

    always_comb begin
        nxt = cur;
        if (cur.one_sec != 4'd0) begin
            nxt.one_sec = cur.one_sec - 4'd1;
        end else begin
            nxt.one_sec = SEC_UNIT_MAX;
            if (cur.ten_sec != 4'd0) begin
                nxt.ten_sec = cur.ten_sec - 4'd1;
            end else begin
                nxt.ten_sec = SEC_TEN_MAX;
                // 0:00 wraps to 9:59 so the result always stays valid BCD
                nxt.one_min = (cur.one_min != 4'd0) ? cur.one_min - 4'd1 : MIN_MAX;
            end
        end
    end

    assign is_zero_next = (cur == 12'h001);

endmodule

// File: rtl/nap_countdown.sv
// Nap countdown: captures the keypad setting on the load rising edge, counts down
// once per 1 Hz tick, then holds the wake alarm for ALARM_SECS ticks.
module nap_countdown
    import nap_pkg::*;
#(
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic [3:0] in_one_sec,
    input  logic [3:0] in_ten_sec,
    input  logic [3:0] in_one_min,
    input  logic       cancel,
    output logic [3:0] rem_one_sec,
    output logic [3:0] rem_ten_sec,
    output logic [3:0] rem_one_min,
    output logic       running,
    output logic       alarm
);

    localparam logic [7:0] ALARM_INIT = 8'(ALARM_SECS);

    nap_state_t state, state_nxt;
    mmss_t      rem, rem_nxt, rem_dec, ld_val;
    logic [7:0] acnt, acnt_nxt;
    logic       load_q, load_rise, dec_zero;

    assign load_rise = load & ~load_q;

    assign ld_val.one_sec = clamp_digit(in_one_sec, SEC_UNIT_MAX);
    assign ld_val.ten_sec = clamp_digit(in_ten_sec, SEC_TEN_MAX);
    assign ld_val.one_min = clamp_digit(in_one_min, MIN_MAX);

    bcd_mmss_dec u_dec (
        .cur          (rem),
        .nxt          (rem_dec),
        .is_zero_next (dec_zero)
    );

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        acnt_nxt  = acnt;
        if (cancel) begin
            state_nxt = ST_IDLE;
            rem_nxt   = '0;
            acnt_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // tick is ignored here, so a coincident load is not decremented
                    if (load_rise) begin
                        if (ld_val == 12'h000) begin
                            rem_nxt = '0;
                        end else begin
                            rem_nxt   = ld_val;
                            state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (tick_1hz) begin
                        if (dec_zero) begin
                            rem_nxt   = '0;
                            acnt_nxt  = ALARM_INIT;
                            state_nxt = ST_ALARM;
                        end else begin
                            rem_nxt = rem_dec;
                        end
                    end
                end
                ST_ALARM: begin
                    rem_nxt = '0;
                    if (tick_1hz) begin
                        if (acnt <= 8'd1) begin
                            acnt_nxt  = '0;
                            state_nxt = ST_IDLE;
                        end else begin
                            acnt_nxt = acnt - 8'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    rem_nxt   = '0;
                    acnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            rem     <= '0;
            acnt    <= '0;
            load_q  <= 1'b0;
            running <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rem     <= rem_nxt;
            acnt    <= acnt_nxt;
            load_q  <= load;
            running <= (state_nxt == ST_RUN);
            alarm   <= (state_nxt == ST_ALARM);
        end
    end

    assign rem_one_sec = rem.one_sec;
    assign rem_ten_sec = rem.ten_sec;
    assign rem_one_min = rem.one_min;

endmodule

// File: tb/tb_nap_countdown.sv
// Self-checking bench for nap_countdown: a seconds-based reference model pushes the
// expected {running, alarm, m:ss} per cycle; each scenario pops and compares it.
module tb_nap_countdown;

    localparam int ALARM_SECS = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0, load = 1'b0, cancel = 1'b0;
    logic [3:0] in_one_sec = '0, in_ten_sec = '0, in_one_min = '0;
    logic [3:0] rem_one_sec, rem_ten_sec, rem_one_min;
    logic       running, alarm;

    int n_cmp = 0;
    int n_err = 0;

    logic [13:0] sb[$];
    logic [13:0] exp_v;

    int m_mode, m_secs, m_acnt;
    bit m_ldq;

    nap_countdown #(.ALARM_SECS(ALARM_SECS)) dut (
        .clock(clock), .reset(reset), .tick_1hz(tick_1hz), .load(load),
        .in_one_sec(in_one_sec), .in_ten_sec(in_ten_sec), .in_one_min(in_one_min),
        .cancel(cancel), .rem_one_sec(rem_one_sec), .rem_ten_sec(rem_ten_sec),
        .rem_one_min(rem_one_min), .running(running), .alarm(alarm)
    );

    always #5 clock = ~clock;

    function automatic logic [13:0] obs();
        return {running, alarm, rem_one_min, rem_ten_sec, rem_one_sec};
    endfunction

    function automatic int lim(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_secs = 0; m_acnt = 0; m_ldq = 0;
    endtask

    // Reference model works in whole seconds, converting to m:ss only for the expectation.
    task automatic model_step(input bit ld, input bit tk, input bit cn);
        int v;
        bit rise;
        rise = ld && !m_ldq;
        if (cn) begin
            m_mode = 0; m_secs = 0; m_acnt = 0;
        end else if (m_mode == 0) begin
            if (rise) begin
                v = lim(int'(in_one_min), 9) * 60 + lim(int'(in_ten_sec), 5) * 10 + lim(int'(in_one_sec), 9);
                m_secs = v;
                if (v > 0) m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (tk) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin m_mode = 2; m_acnt = ALARM_SECS; end
            end
        end else begin
            if (tk) begin
                if (m_acnt == 1) begin m_mode = 0; m_acnt = 0; end
                else m_acnt = m_acnt - 1;
            end
        end
        m_ldq = ld;
        sb.push_back({m_mode == 1, m_mode == 2, 4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10)});
    endtask

    task automatic cyc(input bit ld, input bit tk, input bit cn);
        load = ld; tick_1hz = tk; cancel = cn;
        model_step(ld, tk, cn);
        @(posedge clock); #1;
    endtask

    task automatic set_in(input logic [3:0] m, input logic [3:0] t, input logic [3:0] s);
        in_one_min = m; in_ten_sec = t; in_one_sec = s;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 0; tick_1hz = 0; cancel = 0;
        #3;
        n_cmp++;
        if (obs() !== 14'h0) begin n_err++; $display("FAIL reset_state got=%h want=%h", obs(), 14'h0); end
        @(negedge clock); reset = 1'b0; model_reset();
        @(posedge clock); #1;
    endtask

    task automatic test_count_05();
        set_in(4'd0, 4'd0, 4'd5);
        for (int c = 0; c < 32; c++) begin
            cyc(c == 0, c >= 2 && c % 2 == 0, 1'b0);
            exp_v = sb.pop_front(); n_cmp++;
            if (obs() !== exp_v) begin n_err++; $display("FAIL count_05 c=%0d got=%h want=%h", c, obs(), exp_v); end
            if (c == 8 || c == 10 || c == 28 || c == 30) begin
                exp_v = (c == 8) ? {1'b1, 1'b0, 12'h001} : (c == 30) ? 14'h0 : {1'b0, 1'b1, 12'h000};
                n_cmp++;
                if (obs() !== exp_v) begin n_err++; $display("FAIL count_05_point c=%0d got=%h want=%h", c, obs(), exp_v); end
            end
        end
    endtask

    task automatic test_one_min();
        set_in(4'd1, 4'd0, 4'd0);
        for (int c = 0; c < 62; c++) begin
            cyc(c == 0, c >= 1 && c <= 60, c == 61);
            exp_v = sb.pop_front(); n_cmp++;
            if (obs() !== exp_v) begin n_err++; $display("FAIL one_min c=%0d got=%h want=%h", c, obs(), exp_v); end
            if (c == 1 || c == 59 || c == 60) begin
                exp_v = (c == 1) ? {1'b1, 1'b0, 12'h059} : (c == 59) ? {1'b1, 1'b0, 12'h001} : {1'b0, 1'b1, 12'h000};
                n_cmp++;
                if (obs() !== exp_v) begin n_err++; $display("FAIL one_min_point c=%0d got=%h want=%h", c, obs(), exp_v); end
            end
        end
    endtask

    task automatic test_clamp();
        set_in(4'd15, 4'd7, 4'd12);
        for (int c = 0; c < 3; c++) begin
            cyc(c == 0, c == 1, c == 2);
            exp_v = sb.pop_front(); n_cmp++;
            if (obs() !== exp_v) begin n_err++; $display("FAIL clamp c=%0d got=%h want=%h", c, obs(), exp_v); end
            if (c == 0) begin
                n_cmp++;
                if (obs() !== {1'b1, 1'b0, 12'h959}) begin n_err++; $display("FAIL clamp_capture got=%h want=%h", obs(), {1'b1, 1'b0, 12'h959}); end
            end
        end
    endtask

    task automatic test_cancel_tick();
        set_in(4'd0, 4'd3, 4'd0);
        for (int c = 0; c < 11; c++) begin
            cyc(c == 0, c >= 2 && c % 2 == 0, c == 8);
            exp_v = sb.pop_front(); n_cmp++;
            if (obs() !== exp_v) begin n_err++; $display("FAIL cancel_tick c=%0d got=%h want=%h", c, obs(), exp_v); end
            if (c == 6 || c == 8) begin
                exp_v = (c == 6) ? {1'b1, 1'b0, 12'h027} : 14'h0;
                n_cmp++;
                if (obs() !== exp_v) begin n_err++; $display("FAIL cancel_tick_point c=%0d got=%h want=%h", c, obs(), exp_v); end
            end
        end
    endtask

    task automatic test_load_held();
        set_in(4'd0, 4'd4, 4'd0);
        for (int c = 0; c < 204; c++) begin
            if (c == 200) set_in(4'd0, 4'd0, 4'd9);
            cyc(c < 200 || c == 201 || c == 202, (c < 200 && c % 20 == 10) || c == 202, c == 203);
            exp_v = sb.pop_front(); n_cmp++;
            if (obs() !== exp_v) begin n_err++; $display("FAIL load_held c=%0d got=%h want=%h", c, obs(), exp_v); end
            if (c == 199 || c == 202) begin
                exp_v = (c == 199) ? {1'b1, 1'b0, 12'h030} : {1'b1, 1'b0, 12'h029};
                n_cmp++;
                if (obs() !== exp_v) begin n_err++; $display("FAIL load_held_point c=%0d got=%h want=%h", c, obs(), exp_v); end
            end
        end
    endtask

    task automatic test_zero_and_tick_load();
        logic [13:0] want[7];
        want = '{14'h0, 14'h0, {1'b1, 1'b0, 12'h005}, {1'b1, 1'b0, 12'h005},
                 {1'b1, 1'b0, 12'h004}, 14'h0, 14'h0};
        set_in(4'd0, 4'd0, 4'd0);
        for (int c = 0; c < 7; c++) begin
            if (c == 2) set_in(4'd0, 4'd0, 4'd5);
            cyc(c == 0 || c == 2 || c >= 5, c == 2 || c == 4, c == 5);
            exp_v = sb.pop_front(); n_cmp++;
            if (obs() !== exp_v) begin n_err++; $display("FAIL zero_tick_load c=%0d got=%h want=%h", c, obs(), exp_v); end
            n_cmp++;
            if (obs() !== want[c]) begin n_err++; $display("FAIL zero_tick_load_point c=%0d got=%h want=%h", c, obs(), want[c]); end
        end
        cyc(1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
    endtask

    task automatic test_reset_mid();
        logic [13:0] want[3];
        want = '{{1'b1, 1'b0, 12'h020}, {1'b1, 1'b0, 12'h019}, 14'h0};
        set_in(4'd0, 4'd2, 4'd0);
        for (int c = 0; c < 4; c++) begin
            cyc(1'b1, c >= 1, 1'b0);
            exp_v = sb.pop_front(); n_cmp++;
            if (obs() !== exp_v) begin n_err++; $display("FAIL reset_mid_run c=%0d got=%h want=%h", c, obs(), exp_v); end
        end
        reset = 1'b1;
        #2;
        n_cmp++;
        if (obs() !== 14'h0) begin n_err++; $display("FAIL reset_mid_async got=%h want=%h", obs(), 14'h0); end
        @(negedge clock); reset = 1'b0; model_reset();
        for (int c = 0; c < 3; c++) begin
            cyc(c < 2, c == 1, c == 2);
            exp_v = sb.pop_front(); n_cmp++;
            if (obs() !== exp_v) begin n_err++; $display("FAIL reset_mid_after c=%0d got=%h want=%h", c, obs(), exp_v); end
            n_cmp++;
            if (obs() !== want[c]) begin n_err++; $display("FAIL reset_mid_point c=%0d got=%h want=%h", c, obs(), want[c]); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count_05();
        test_one_min();
        test_clamp();
        test_cancel_tick();
        test_load_held();
        test_zero_and_tick_load();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
